// File: rtl/matrix_face_player.sv
// 8x8 LED matrix face player: scans one of four faces for a fixed number of
// frames, optionally drives a square-wave buzzer, then reports done.
module matrix_face_player #(
    parameter int SCAN_DIV       = 4,
    parameter int BEEP_HALF      = 11,
    parameter int FRAMES         = 50,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] face_sel,
    input  logic       beep_en,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       beep,
    output logic       busy,
    output logic       done
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam int FW = (FRAMES    > 1) ? $clog2(FRAMES)    : 1;

    localparam logic [7:0] ROW_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

    // Face bitmaps, row 0 in the most significant byte.
    localparam logic [63:0] FACE_SMILE = 64'h00_66_66_66_00_42_24_18;
    localparam logic [63:0] FACE_FROWN = 64'h00_66_66_66_00_18_24_42;
    localparam logic [63:0] FACE_CROSS = 64'h81_42_24_18_18_24_42_81;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      face_q, face_d;
    logic            beep_en_q, beep_en_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [2:0]      row_idx_q, row_idx_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
    logic [7:0]      row_q, row_d;
    logic [7:0]      col_q, col_d;
    logic            beep_q, beep_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      row_onehot;

    function automatic logic [7:0] face_rom(input logic [1:0] f, input logic [2:0] r);
        logic [63:0] bits;
        case (f)
            2'd0:    bits = FACE_SMILE;
            2'd1:    bits = FACE_FROWN;
            2'd2:    bits = FACE_CROSS;
            default: bits = 64'd0;
        endcase
        return bits[(7 - int'(r)) * 8 +: 8];
    endfunction

    // Next-state: start has priority over everything, including completion.
    always_comb begin
        state_d     = state_q;
        face_d      = face_q;
        beep_en_d   = beep_en_q;
        scan_cnt_d  = scan_cnt_q;
        row_idx_d   = row_idx_q;
        frame_cnt_d = frame_cnt_q;
        beep_cnt_d  = beep_cnt_q;
        beep_d      = beep_q;
        if (start) begin
            state_d     = SHOW;
            face_d      = face_sel;
            beep_en_d   = beep_en;
            scan_cnt_d  = '0;
            row_idx_d   = '0;
            frame_cnt_d = '0;
            beep_cnt_d  = '0;
            beep_d      = 1'b0;
        end else if (state_q == SHOW) begin
            if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
                scan_cnt_d = '0;
                if (row_idx_q == 3'd7) begin
                    row_idx_d = '0;
                    if (frame_cnt_q == FW'(FRAMES - 1)) begin
                        state_d     = DONE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end else begin
                    row_idx_d = row_idx_q + 3'd1;
                end
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
            if (beep_cnt_q == BW'(BEEP_HALF - 1)) begin
                beep_cnt_d = '0;
                beep_d     = beep_en_q ? ~beep_q : 1'b0;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
            end
            // Leaving SHOW silences the buzzer and parks the beep counter.
            if (state_d != SHOW) begin
                beep_cnt_d = '0;
                beep_d     = 1'b0;
            end
        end
    end

    // Row decoder for the row that will be lit after this edge.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_row_dec
            assign row_onehot[gi] = (row_idx_d == 3'(gi));
        end
    endgenerate

    // Output values registered alongside the state so they change together.
    always_comb begin
        row_d  = ROW_IDLE;
        col_d  = 8'h00;
        busy_d = 1'b0;
        done_d = (state_d == DONE);
        if (state_d == SHOW) begin
            row_d  = ROW_ACTIVE_LOW ? ~row_onehot : row_onehot;
            col_d  = face_rom(face_d, row_idx_d);
            busy_d = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            face_q      <= 2'd0;
            beep_en_q   <= 1'b0;
            scan_cnt_q  <= '0;
            row_idx_q   <= '0;
            frame_cnt_q <= '0;
            beep_cnt_q  <= '0;
            row_q       <= ROW_IDLE;
            col_q       <= 8'h00;
            beep_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            face_q      <= face_d;
            beep_en_q   <= beep_en_d;
            scan_cnt_q  <= scan_cnt_d;
            row_idx_q   <= row_idx_d;
            frame_cnt_q <= frame_cnt_d;
            beep_cnt_q  <= beep_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            beep_q      <= beep_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign beep = beep_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_matrix_face_player.sv
// Testbench for matrix_face_player: two builds (active-low and active-high rows)
// checked every cycle against a cycles-since-start arithmetic model.
module tb_matrix_face_player;

    localparam int  SA = 2, BA = 5, FA = 3;   // active-low build
    localparam int  SB = 3, BB = 4, FB = 3;   // active-high build

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] face_sel;
    logic       beep_en;
    logic [7:0] row_a, col_a, row_b, col_b;
    logic       beep_a, busy_a, done_a, beep_b, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    matrix_face_player #(.SCAN_DIV(SA), .BEEP_HALF(BA), .FRAMES(FA), .ROW_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .face_sel(face_sel), .beep_en(beep_en),
        .row(row_a), .col(col_a), .beep(beep_a), .busy(busy_a), .done(done_a)
    );

    matrix_face_player #(.SCAN_DIV(SB), .BEEP_HALF(BB), .FRAMES(FB), .ROW_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .face_sel(face_sel), .beep_en(beep_en),
        .row(row_b), .col(col_b), .beep(beep_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Face table, rows 0..7.
    logic [7:0] rom [4][8];
    initial begin
        rom[0] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18};
        rom[1] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h18, 8'h24, 8'h42};
        rom[2] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        rom[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    end

    // Model state: cycles elapsed since the last accepted start.
    int         n_m = 0;
    bit         started_m = 1'b0;
    logic [1:0] face_m = 2'd0;
    bit         ben_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_m <= 1'b0;
            n_m       <= 0;
        end else if (start) begin
            started_m <= 1'b1;
            n_m       <= 0;
            face_m    <= face_sel;
            ben_m     <= beep_en;
        end else if (started_m) begin
            n_m <= n_m + 1;
        end
    end

    // Expected {row, col, beep, busy, done} n cycles after a start.
    function automatic logic [18:0] expect_out(int n, bit st, int s, int f, int b, bit al,
                                               logic [1:0] fc, bit be);
        logic [7:0] r_idle, r_on, c;
        int         r;
        r_idle = al ? 8'hFF : 8'h00;
        if (!st)
            return {r_idle, 8'h00, 1'b0, 1'b0, 1'b0};
        if (n >= 8 * s * f)
            return {r_idle, 8'h00, 1'b0, 1'b0, 1'b1};
        r    = (n / s) % 8;
        r_on = 8'h01 << r;
        if (al) r_on = ~r_on;
        c = rom[fc][r];
        return {r_on, c, (be && ((n / b) % 2 == 1)), 1'b1, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", nm, act, exp, $time, n_m);
        end
    endtask

    logic [18:0] ea, eb;

    // Single compare process: model check each cycle plus literal pins.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_row_a", row_a, 8'hFF);
            chk("rst_col_a", col_a, 8'h00);
            chk("rst_beep_a", beep_a, 0);
            chk("rst_busy_a", busy_a, 0);
            chk("rst_done_a", done_a, 0);
            chk("rst_row_b", row_b, 8'h00);
            chk("rst_busy_b", busy_b, 0);
        end else begin
            ea = expect_out(n_m, started_m, SA, FA, BA, 1'b1, face_m, ben_m);
            eb = expect_out(n_m, started_m, SB, FB, BB, 1'b0, face_m, ben_m);
            chk("row_a", row_a, ea[18:11]);
            chk("col_a", col_a, ea[10:3]);
            chk("beep_a", beep_a, ea[2]);
            chk("busy_a", busy_a, ea[1]);
            chk("done_a", done_a, ea[0]);
            chk("row_b", row_b, eb[18:11]);
            chk("col_b", col_b, eb[10:3]);
            chk("beep_b", beep_b, eb[2]);
            chk("busy_b", busy_b, eb[1]);
            chk("done_b", done_b, eb[0]);
            if (started_m) begin
                if (n_m == 0) begin
                    chk("lit_first_row_a", row_a, 8'hFE);
                    chk("lit_first_busy_a", busy_a, 1);
                    chk("lit_first_row_b", row_b, 8'h01);
                end
                if (n_m == 3) chk("lit_row1_b", row_b, 8'h02);
                if (n_m == 2 && face_m == 2'd0) begin
                    chk("lit_smile_row1_a", row_a, 8'hFD);
                    chk("lit_smile_col1_a", col_a, 8'h66);
                end
                if (n_m == 14 && face_m == 2'd0) begin
                    chk("lit_smile_row7_a", row_a, 8'h7F);
                    chk("lit_smile_col7_a", col_a, 8'h18);
                end
                if (n_m == 10 && face_m == 2'd1) chk("lit_frown_col5_a", col_a, 8'h18);
                if (n_m == 0 && face_m == 2'd2) chk("lit_cross_col0_a", col_a, 8'h81);
                if (n_m == 4 && ben_m) chk("lit_beep4_a", beep_a, 0);
                if (n_m == 5 && ben_m) chk("lit_beep5_a", beep_a, 1);
                if (n_m == 4 && ben_m) chk("lit_beep4_b", beep_b, 1);
                if (n_m == 47) chk("lit_busy47_a", busy_a, 1);
                if (n_m == 48) begin
                    chk("lit_done48_a", done_a, 1);
                    chk("lit_row48_a", row_a, 8'hFF);
                    chk("lit_busy48_a", busy_a, 0);
                end
                if (n_m == 72) chk("lit_done72_b", done_b, 1);
            end
        end
    end

    // Raise start for exactly one edge; call at a falling edge.
    task automatic pulse(input logic [1:0] f, input logic be);
        start    = 1'b1;
        face_sel = f;
        beep_en  = be;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        face_sel = 2'd0;
        beep_en  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Smile, no beep, run through completion of both builds.
        pulse(2'd0, 1'b0);
        repeat (80) @(negedge clk);

        // Cross with beep; late face/beep changes must be ignored.
        pulse(2'd2, 1'b1);
        repeat (20) @(negedge clk);
        face_sel = 2'd3;
        beep_en  = 1'b0;
        repeat (60) @(negedge clk);

        // Restart at cycle 20 of a smile run with a frown.
        pulse(2'd0, 1'b0);
        repeat (19) @(negedge clk);
        pulse(2'd1, 1'b1);
        repeat (60) @(negedge clk);

        // Start landing on the same edge as dut_a completion.
        pulse(2'd2, 1'b0);
        repeat (47) @(negedge clk);
        pulse(2'd0, 1'b1);
        repeat (80) @(negedge clk);

        // Start while DONE.
        pulse(2'd1, 1'b0);
        repeat (30) @(negedge clk);

        // Randomised runs with input noise and occasional async reset.
        for (int i = 0; i < 40; i++) begin
            pulse(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int c = $urandom_range(0, 90); c > 0; c--) begin
                face_sel = 2'($urandom_range(0, 3));
                beep_en  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if ($urandom_range(0, 7) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Explicit asynchronous reset in the middle of a run.
        pulse(2'd0, 1'b1);
        repeat (10) @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_face_player.md
Name: matrix_face_player

Overview:
- Drives an 8x8 LED dot matrix (row scan + column data) with one of four selectable faces for a fixed number of full frames, with an optional square-wave buzzer.
- Signals completion so the game controller can re-arm.
- Parametrised successor of the fixed success-face scanner: adds configurable scan rate, beep rate, display duration, row polarity, face selection and a start/busy/done handshake.

Parameters:
- SCAN_DIV, 4, clk cycles each row stays lit (>=1).
- BEEP_HALF, 11, clk cycles per beep half-period (>=1).
- FRAMES, 50, full 8-row frames shown before completion (>=1).
- ROW_ACTIVE_LOW, 1, 1: lit row driven 0 and others 1; 0: lit row driven 1 and others 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; starts or restarts display.
- face_sel  input  2  0 smile, 1 frown, 2 cross (X), 3 blank; sampled on start.
- beep_en  input  1  enables buzzer for this run; sampled on start.
- row  output  8  row select, bit i = row i, polarity per ROW_ACTIVE_LOW.
- col  output  8  column data for the lit row, 1 = LED on, bit7 = leftmost.
- beep  output  1  buzzer square wave.
- busy  output  1  high while displaying.
- done  output  1  high from completion until next start.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: state IDLE, row all inactive (8'hFF if ROW_ACTIVE_LOW else 8'h00), col 0, beep 0, busy 0, done 0, all counters 0.
- All outputs registered. Reset mid-run aborts immediately to these values.
- States:
  - IDLE: outputs at reset values; start -> SHOW.
  - SHOW: busy=1; scanning runs; last row of frame FRAMES-1 finishing its SCAN_DIV cycles -> DONE.
  - DONE: busy=0, done=1, row inactive, col 0, beep 0; start -> SHOW.
- Start (any state): latch face_sel and beep_en; clear scan, row, frame and beep counters; clear done. Start during SHOW restarts from row 0 frame 0 with the newly latched face.
- Latency: start sampled at edge k -> after edge k, row shows row 0 active, col shows face row 0, busy=1.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. On terminal count, row index advances 0..7 and wraps to 0.
  - On the 7->0 wrap, frame_cnt increments.
  - Exactly one row bit active in SHOW.
  - Total SHOW duration = 8*SCAN_DIV*FRAMES cycles. done rises on the edge ending that interval.
- Face ROM, rows 0..7:
  - smile: 00,66,66,66,00,42,24,18.
  - frown: 00,66,66,66,00,18,24,42.
  - cross: 81,42,24,18,18,24,42,81.
  - blank: all 00.
- Beep: in SHOW with latched beep_en=1, beep toggles every BEEP_HALF cycles, starting from 0 at start. With beep_en=0, beep stays 0. beep is forced 0 on leaving SHOW.
- face_sel and beep_en changes outside a start cycle have no effect.
- start and completion on the same edge: start wins (restart, done stays 0).
- Counter widths sized by $clog2 of each limit. No overflow or wrap beyond the defined ranges.

Test Plan:
- Reset: rst_n=0 mid-SHOW -> immediately row=FF, col=00, beep=0, busy=0, done=0, asynchronous to clk.
- SCAN_DIV=2, FRAMES=3, face_sel=0, start at edge 0:
  - row=FE with col=00 for 2 cycles, then FD with col=66, through row 7 with col=18.
  - busy high for exactly 48 cycles, then done=1, row=FF.
- face_sel=2, beep_en=1, BEEP_HALF=5 -> col sequence 81,42,24,18,18,24,42,81 repeats; beep toggles every 5 cycles; beep=0 once done.
- Restart: start at cycle 20 of a smile run with face_sel=1 -> next cycle row=FE, frame_cnt 0; row 5 shows 18; done delayed to 48 cycles after restart.
- Late inputs: face_sel and beep_en toggled mid-SHOW without start -> displayed face and beep unchanged.
- ROW_ACTIVE_LOW=0 build -> idle row=00, lit row is one-hot high (01,02,...,80); start during DONE clears done next cycle.
